// File: rtl/mult_seq.sv
// mult_seq: sequential signed WIDTHxWIDTH multiplier, one shift-add step per cycle
module mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] ma, mb;
  logic sgn, last, accept;
  logic [2*WIDTH-1:0] acc, sum;
  logic [CW-1:0] cnt;
  assign last = cnt == CW'(WIDTH - 1);
  assign accept = state == IDLE && in_valid;
  // mb is shifted right each step, so bit 0 is always the current multiplier bit
  assign sum = acc + (mb[0] ? ({{WIDTH{1'b0}}, ma} << cnt) : '0);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = state == IDLE ? (in_valid ? CALC : IDLE) :
                state == CALC ? (last ? HOLD : CALC) :
                                (out_ready ? IDLE : HOLD);
  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == HOLD;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ma <= '0;
      mb <= '0;
      sgn <= 1'b0;
      acc <= '0;
      cnt <= '0;
      p <= '0;
    end else if (accept) begin
      ma <= a[WIDTH-1] ? -a : a;
      mb <= b[WIDTH-1] ? -b : b;
      sgn <= a[WIDTH-1] ^ b[WIDTH-1];
      acc <= '0;
      cnt <= '0;
    end else if (state == CALC) begin
      acc <= sum;
      mb <= mb >> 1;
      cnt <= cnt + CW'(1);
      if (last) p <= sgn ? -sum : sum;
    end
endmodule

// File: tb/tb_mult_seq.sv
// tb_mult_seq: randomized and directed checks of mult_seq against an arithmetic product model
module tb_mult_seq;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic in_ready, out_valid;
  logic [63:0] p;
  int checks = 0, errors = 0;

  mult_seq dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
                .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .p(p));

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    return 64'(sx * sy);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // accept one pair, wait for the product, stall for 'stall' cycles, then hand it off
  task automatic run(input string name, input logic [31:0] x, input logic [31:0] y,
                     input logic [63:0] exp, input int stall, input bit poke);
    int cyc = 0;
    while (!in_ready && cyc < 100) begin step(); cyc++; end
    chk({name, "_ready"}, 64'(in_ready), 64'd1);
    a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = poke;
    a = $urandom; b = $urandom;
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      chk({name, "_busy"}, 64'(in_ready), 64'd0);
      out_ready = $urandom_range(0, 1);
      step();
      cyc++;
    end
    out_ready = 1'b0;
    chk({name, "_lat"}, 64'(cyc), 64'd32);
    chk({name, "_p"}, p, exp);
    for (int i = 0; i < stall; i++) begin
      step();
      if (poke) in_valid = ~in_valid;
      chk({name, "_hold_v"}, 64'(out_valid), 64'd1);
      chk({name, "_hold_p"}, p, exp);
    end
    out_ready = 1'b1;
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    chk({name, "_idle_rdy"}, 64'(in_ready), 64'd1);
    chk({name, "_idle_v"}, 64'(out_valid), 64'd0);
    chk({name, "_idle_p"}, p, exp);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1;
    step(); step();
    chk("rst_rdy", 64'(in_ready), 64'd1);
    chk("rst_v", 64'(out_valid), 64'd0);
    chk("rst_p", p, 64'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_directed();
    run("neg", 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 0, 1'b0);
    run("minmin", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 0, 1'b0);
    run("minone", 32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000, 1, 1'b0);
    run("zero", 32'd0, 32'h7FFF_FFFF, 64'd0, 0, 1'b0);
    run("maxmax", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, 0, 1'b0);
    run("negzero", 32'hFFFF_FFFF, 32'd0, 64'd0, 0, 1'b0);
  endtask

  task automatic test_hold();
    run("hold", 32'h1234_5678, 32'hFEDC_BA98, ref_mul(32'h1234_5678, 32'hFEDC_BA98), 10, 1'b1);
    step();
    chk("hold_no2nd_v", 64'(out_valid), 64'd0);
    chk("hold_no2nd_rdy", 64'(in_ready), 64'd1);
  endtask

  task automatic test_reset_mid();
    a = 32'd1000; b = 32'd77; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 16; i++) step();
    rst_n = 1'b0;
    #1;
    chk("mid_v_async", 64'(out_valid), 64'd0);
    chk("mid_rdy_async", 64'(in_ready), 64'd1);
    step();
    chk("mid_p", p, 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("mid_no_out", 64'(out_valid), 64'd0);
    end
    run("mid_next", 32'd5, 32'd6, 64'd30, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] x, y;
    for (int n = 0; n < 1000; n++) begin
      x = $urandom;
      y = $urandom;
      if (n % 16 == 0) x = {$urandom_range(0, 1) ? 1'b1 : 1'b0, 31'd0};
      if (n % 23 == 0) y = 32'($urandom_range(0, 3)) - 32'd1;
      run("rand", x, y, ref_mul(x, y), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
